// File: rtl/fpu_pkg.sv
// Shared constants for the 16-bit FPU datapath: exponent limits, mantissa
// bit positions of the unnormalized working format, and FSM state codes.
package fpu_pkg;

    localparam int FP16_BIAS = 15;
    localparam int EXP_MAX   = 31;

    localparam int MANT_W   = 14;
    localparam int M_CARRY  = 13;
    localparam int M_HIDDEN = 12;
    localparam int M_LSB    = 2;
    localparam int M_GUARD  = 1;
    localparam int M_RND    = 0;

    // Working exponent is one bit wider than in_exp so a carry shift cannot wrap.
    localparam int EXP_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t ROUND = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/fp16_round_rne.sv
// Combinational round-to-nearest-even and binary16 packing of a normalized
// (or subnormal) working mantissa; shared with the multiply stage.
module fp16_round_rne
    import fpu_pkg::*;
(
    input  logic              s,
    input  logic [EXP_W-1:0]  e,
    input  logic [MANT_W-1:0] m,
    input  logic              st,
    output logic [15:0]       result,
    output logic              overflow,
    output logic              inexact
);

    logic        up;
    logic [11:0] sum;
    logic [8:0]  exp_f;
    logic [9:0]  frac;

    always_comb begin
        up       = m[M_GUARD] & (m[M_RND] | st | m[M_LSB]);
        sum      = {1'b0, m[M_HIDDEN:M_LSB]} + {11'd0, up};
        exp_f    = 9'd0;
        frac     = 10'd0;
        result   = 16'h0000;
        overflow = 1'b0;
        inexact  = m[M_GUARD] | m[M_RND] | st;

        if (sum[11]) begin
            exp_f = {1'b0, e} + 9'd1;
            frac  = 10'd0;
        end else begin
            // Hidden bit clear means subnormal; rounding into bit 10 makes it normal.
            exp_f = sum[10] ? {1'b0, e} : 9'd0;
            frac  = sum[9:0];
        end

        if (exp_f >= 9'(EXP_MAX)) begin
            result   = {s, 5'h1F, 10'h000};
            overflow = 1'b1;
        end else begin
            result = {s, exp_f[4:0], frac};
        end
    end

endmodule

// File: rtl/fp16_normalize_round.sv
// Post-normalize and round stage: one normalization shift per cycle, then
// RNE rounding, with a single operation in flight behind valid/ready.
module fp16_normalize_round
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [13:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_overflow,
    output logic        out_inexact,
    output logic [1:0]  dbg_state
);

    // Handshake: a beat moves on either side only when valid and ready are both
    // high at a rising clk edge; out_valid holds with stable data until taken.

    state_t              state;
    logic [MANT_W-1:0]   m;
    logic [EXP_W-1:0]    e;
    logic                s;
    logic                st;

    logic [15:0]         rnd_result;
    logic                rnd_overflow;
    logic                rnd_inexact;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    fp16_round_rne u_round (
        .s        (s),
        .e        (e),
        .m        (m),
        .st       (st),
        .result   (rnd_result),
        .overflow (rnd_overflow),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            m            <= '0;
            e            <= '0;
            s            <= 1'b0;
            st           <= 1'b0;
            out_result   <= 16'h0000;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s  <= in_sign;
                        e  <= (in_exp == 7'd0) ? 8'd1 : {1'b0, in_exp};
                        m  <= in_mant;
                        st <= in_sticky;
                        if (in_mant == '0 && !in_sticky) begin
                            out_result   <= {in_sign, 15'h0000};
                            out_overflow <= 1'b0;
                            out_inexact  <= 1'b0;
                            state        <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (m[M_CARRY]) begin
                        m     <= {1'b0, m[MANT_W-1:1]};
                        st    <= st | m[0];
                        e     <= e + 8'd1;
                        state <= ROUND;
                    end else if (!m[M_HIDDEN] && e > 8'd1) begin
                        m <= {m[MANT_W-2:0], 1'b0};
                        e <= e - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_result   <= rnd_result;
                    out_overflow <= rnd_overflow;
                    out_inexact  <= rnd_inexact;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
